// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter.
//   state_e       : converter FSM states
//   BCD_DIGIT_W   : bits per BCD digit
//   BCD_MAX_DIGIT : largest legal decimal digit
//   min_bin_w()   : smallest binary width that holds every DIGITS-digit decimal value
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  // Bits needed for 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int unsigned min_bin_w(int unsigned digits);
    longint unsigned max_val;
    int unsigned     bits;
    max_val = 1;
    bits    = 0;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    while (max_val != 0) begin
      bits++;
      max_val = max_val >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/bcd_to_binary_mac.sv
// Combinational multiply-by-ten-and-add step of the BCD to binary conversion.
//   acc_i           : running accumulator
//   digit_i         : next BCD digit, MSD first
//   sum_o           : acc_i*10 + digit_i, modulo 2^BIN_W
//   digit_invalid_o : digit_i is not a decimal digit (>9)
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 10
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]       sum_o,
  output logic                   digit_invalid_o
);

  // x*10 as two shifts and an add; invalid digits are added at their raw value.
  always_comb begin
    sum_o           = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
    digit_invalid_o = digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
//   clk, reset     : clock and synchronous active-high reset
//   in_valid/ready : input handshake; in_ready is high only while idle
//   bcd_input      : packed BCD word, digit DIGITS-1 in the MSBs
//   out_valid/ready: output handshake; result held until accepted
//   binary_output  : converted value (registered copy of the accumulator)
//   error          : some nibble of the accepted word was >9, qualified by out_valid
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_input,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              binary_output,
  output logic                          error
);

  localparam int unsigned SrW  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
    $error("BIN_W is too narrow for DIGITS decimal digits");
  end

  state_e           state_q;
  logic [SrW-1:0]   sr_q;
  logic [BIN_W-1:0] acc_q;
  logic [BIN_W-1:0] acc_d;
  logic [CntW-1:0]  cnt_q;
  logic             err_q;
  logic [BIN_W-1:0] bin_q;
  logic             out_valid_q;
  logic             digit_invalid;

  bcd_digit_mac #(
    .BIN_W(BIN_W)
  ) u_mac (
    .acc_i          (acc_q),
    .digit_i        (sr_q[SrW-1 -: BCD_DIGIT_W]),
    .sum_o          (acc_d),
    .digit_invalid_o(digit_invalid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sr_q    <= bcd_input;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StConv;
          end
        end
        StConv: begin
          acc_q <= acc_d;
          bin_q <= acc_d;
          sr_q  <= sr_q << BCD_DIGIT_W;
          cnt_q <= cnt_q + CntW'(1);
          if (digit_invalid) begin
            err_q <= 1'b1;
          end
          if (cnt_q == CntW'(DIGITS - 1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready depends on state alone so no input reaches an output combinationally.
  always_comb begin
    in_ready      = (state_q == StIdle);
    out_valid     = out_valid_q;
    binary_output = bin_q;
    error         = err_q;
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      bcd_input;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] binary_output;
  logic             error;

  int checks;
  int errors;

  bcd_to_binary #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bcd_input    (bcd_input),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .binary_output(binary_output),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic xfer(input string nm, input logic [11:0] bcd, input logic [9:0] exp,
                      input logic exp_err, input int hold);
    int cyc;
    chk({nm, ".in_ready_before"}, {31'd0, in_ready}, 1);
    bcd_input = bcd;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    bcd_input = 12'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({nm, ".latency"}, cyc, DIGITS);
    chk({nm, ".out_valid"}, {31'd0, out_valid}, 1);
    chk({nm, ".binary"}, {22'd0, binary_output}, {22'd0, exp});
    chk({nm, ".error"}, {31'd0, error}, {31'd0, exp_err});
    chk({nm, ".in_ready_done"}, {31'd0, in_ready}, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".hold_valid"}, {31'd0, out_valid}, 1);
      chk({nm, ".hold_binary"}, {22'd0, binary_output}, {22'd0, exp});
      chk({nm, ".hold_error"}, {31'd0, error}, {31'd0, exp_err});
      chk({nm, ".hold_in_ready"}, {31'd0, in_ready}, 0);
      in_valid  = 1'($urandom_range(0, 1));
      bcd_input = 12'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".in_ready_after"}, {31'd0, in_ready}, 1);
    chk({nm, ".out_valid_after"}, {31'd0, out_valid}, 0);
    chk({nm, ".binary_held"}, {22'd0, binary_output}, {22'd0, exp});
  endtask

  initial begin
    logic [11:0] w;
    logic [9:0]  wv;
    logic [9:0]  q_bin[$];
    logic [9:0]  e;
    bit          acc_flag;
    int          sent;
    int          got;
    int          cyc;
    int          d;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_input = '0;

    vecs[0] = '{12'h255, 10'd255, 1'b0, 0};
    vecs[1] = '{12'h000, 10'd0,   1'b0, 0};
    vecs[2] = '{12'h999, 10'd999, 1'b0, 0};
    vecs[3] = '{12'h001, 10'd1,   1'b0, 0};
    vecs[4] = '{12'h1A3, 10'd203, 1'b1, 0};
    vecs[5] = '{12'h042, 10'd42,  1'b0, 0};
    vecs[6] = '{12'h0F0, 10'd150, 1'b1, 0};
    vecs[7] = '{12'hFFF, 10'd641, 1'b1, 0};  // 1665 mod 1024
    vecs[8] = '{12'h864, 10'd864, 1'b0, 10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.in_ready", {31'd0, in_ready}, 1);
    chk("reset.out_valid", {31'd0, out_valid}, 0);
    chk("reset.binary", {22'd0, binary_output}, 0);
    chk("reset.error", {31'd0, error}, 0);

    for (int i = 0; i < 9; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].hold);
    end

    // Reset during the second CONV cycle discards the word.
    bcd_input = 12'h777;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset.out_valid", {31'd0, out_valid}, 0);
    chk("midreset.in_ready", {31'd0, in_ready}, 1);
    chk("midreset.binary", {22'd0, binary_output}, 0);
    // Reset wins over a simultaneous in_valid.
    bcd_input = 12'h555;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset_vs_valid.in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    chk("reset_vs_valid.still_idle", {31'd0, in_ready}, 1);
    chk("reset_vs_valid.no_result", {31'd0, out_valid}, 0);
    xfer("after_reset", 12'h123, 10'd123, 1'b0, 0);

    // Random stream with gaps on both handshakes, checked against an in-order scoreboard.
    sent     = 0;
    got      = 0;
    cyc      = 0;
    acc_flag = 1'b0;
    wv       = '0;
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc_flag) begin
        in_valid = 1'b0;
        acc_flag = 1'b0;
      end
      if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        w  = '0;
        wv = '0;
        for (int k = 0; k < 3; k++) begin
          d  = $urandom_range(0, 9);
          w  = {w[7:0], 4'(d)};
          wv = 10'(wv * 10 + d);
        end
        bcd_input = w;
        in_valid  = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q_bin.push_back(wv);
        sent++;
        acc_flag = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q_bin.size() == 0) begin
          chk("stream.unexpected_result", 1, 0);
        end else begin
          e = q_bin.pop_front();
          chk("stream.binary", {22'd0, binary_output}, {22'd0, e});
          chk("stream.error", {31'd0, error}, 0);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    chk("stream.count", got, 1000);
    chk("stream.leftover", q_bin.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential packed-BCD to unsigned binary converter; the inverse of the team's binary-to-BCD display path. It is used where operator or keypad digits arrive as BCD and must be turned back into binary for counters and comparators. The block converts one digit per clock, most significant digit first, using multiply-by-ten accumulation. It has valid/ready handshakes on both sides and flags any non-decimal nibble.

## Interface
- DIGITS, 3, number of BCD digits in the input word (≥1)
- BIN_W, 10, binary result width; must be ≥ ceil(log2(10^DIGITS))
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; one clock domain, reset sampled on clk rising edge
- in_valid  input  1  bcd_input is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- bcd_input  input  4*DIGITS  packed BCD, digit DIGITS-1 in the MSBs
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts the result
- binary_output  output  BIN_W  converted value
- error  output  1  at least one nibble of the accepted word was >9; qualified by out_valid

## Operation
- Three states: IDLE, CONV, DONE. Reset forces IDLE, in the same edge, from any state.
- IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - bcd_input is latched into an internal digit shift register.
  - The accumulator is set to 0, the digit counter to 0 and error to 0.
  - The state moves to CONV.
- CONV, each cycle:
  - acc <= acc*10 + d, where d is the top nibble of the shift register. The multiply is (acc<<3)+(acc<<1).
  - The shift register shifts left by 4.
  - The counter increments.
  - error is set sticky if d>9.
  - When the counter reaches DIGITS-1, the state moves to DONE.
- DONE: out_valid=1. binary_output and error are stable. On out_ready the state moves to IDLE.
- Arithmetic:
  - The accumulator is BIN_W bits; results are modulo 2^BIN_W.
  - Invalid digits are accumulated at their raw value (10–15). No saturation.
  - Results for valid input are exact.
- in_valid is ignored outside IDLE; no input data is dropped silently, because in_ready=0 there.
- bcd_input changes after acceptance have no effect.

## Timing
- Reset values:
  - in_ready=1 (IDLE)
  - out_valid=0
  - binary_output=0
  - error=0
  - internal accumulator, counter and shift register all 0
- Latency: the word is accepted at edge T, and out_valid rises after edge T+DIGITS (3 cycles default).
- Throughput:
  - out_ready held high: out_valid is high for one cycle, and IDLE is re-entered on the next edge.
  - Minimum accept-to-accept spacing is DIGITS+2 cycles.
- in_ready is combinational from state only. There is no combinational path from in_valid or out_ready to any output.
- binary_output is a registered copy of the accumulator. It holds its last value in IDLE and is only updated in CONV.
- Back-pressure: in DONE with out_ready=0, all outputs are held indefinitely.
- Reset mid-CONV or mid-DONE: the pending result is discarded, and out_valid is 0 on the cycle after reset.
- Reset and in_valid in the same cycle: reset wins, and nothing is accepted.
- DIGITS=1: CONV lasts exactly one cycle.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, CONV, DONE)
  - BCD_DIGIT_W=4
  - BCD_MAX_DIGIT=9
  - a function computing the minimum BIN_W from DIGITS
- Elaboration check: BIN_W ≥ the package minimum.
- Natural sub-module: bcd_digit_mac. It is combinational and computes acc*10+digit, plus digit_invalid (digit>9), at width BIN_W. The top level holds the FSM, counter, shift register and registers.

## Test plan
- Reset, then apply 0x255 with out_ready=1 → out_valid exactly 3 cycles after accept, binary_output=255, error=0; in_ready returns high the next cycle.
- Boundaries: 0x000 → 0, 0x999 → 999, 0x001 → 1; all with error=0.
- Invalid nibble 0x1A3 → error=1, binary_output=1*100+10*10+3=203; a following 0x042 → error=0, binary_output=42.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid, binary_output and error stay stable, and in_ready=0.
  - Toggle bcd_input and in_valid during that window → the result is unchanged.
- Assert reset during the second CONV cycle of 0x777 → the next cycle shows out_valid=0 and in_ready=1; a subsequent 0x123 → 123.
- Random back-to-back stream of 1000 valid words, with random in_valid and out_ready gaps → every result matches the decimal value, in order, with none lost or duplicated.
